// File: rtl/sysbus_pkg.sv
// ============================================================================
// Module      : sysbus_pkg
// Description : Sysbus tag field layout, command/type codes and FSM states
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sysbus_pkg;

    localparam int c_TAG_TYPE_BIT = 12;
    localparam int c_TAG_CMD_HI   = 11;
    localparam int c_TAG_CMD_LO   = 8;

    localparam logic       c_SYSBUS_MEMORY = 1'b1;
    localparam logic [3:0] c_SYSBUS_READ   = 4'b0001;
    localparam logic [3:0] c_SYSBUS_WRITE  = 4'b0010;

    localparam int c_LINE_BYTES = 64;
    localparam int c_BEAT_BYTES = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCEPT = 3'd1,
        WDATA  = 3'd2,
        DELAY  = 3'd3,
        RESP   = 3'd4
    } sysbus_state_t;

endpackage

`default_nettype wire

// File: rtl/sysbus_mem_array.sv
// ============================================================================
// Module      : sysbus_mem_array
// Description : Synchronous word RAM, one write port and one registered read
//               port with a synchronous clear of the read register
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sysbus_mem_array #(
    parameter int MEM_WORDS  = 4096,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = $clog2(MEM_WORDS)
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic                  i_rd_clr,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];
    logic [DATA_WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // The read register doubles as the responder's data output, so it must
    // be clearable independently of the array contents.
    always_ff @(posedge clk) begin
        if (i_rd_clr) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/sysbus_mem_responder.sv
// ============================================================================
// Module      : sysbus_mem_responder
// Description : Sysbus memory-side responder serving 64-byte lines as eight
//               64-bit beats. Define SYSBUS_CRITWORD_EN for critical-word-first
//               read ordering.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sysbus_mem_responder
    import sysbus_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int MEM_WORDS      = 4096,
    parameter int LINE_BEATS     = 8,
    parameter int LATENCY        = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_reqack,
    output logic                      bus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    input  logic                      bus_respack
);

    localparam int c_ADDR_WIDTH = $clog2(MEM_WORDS);
    localparam int c_BEAT_W     = $clog2(LINE_BEATS);
    localparam int c_LINE_SHIFT = $clog2(c_LINE_BYTES);
    localparam int c_LINE_IDX_W = c_ADDR_WIDTH - c_BEAT_W;
    localparam int c_DLY_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(LINE_BEATS - 1);

    sysbus_state_t             r_state;
    logic [c_LINE_IDX_W-1:0]   r_line;
    logic [BUS_TAG_WIDTH-1:0]  r_tag;
    logic [c_BEAT_W-1:0]       r_beat;
    logic [c_DLY_W-1:0]        r_delay;
    logic                      r_reqack;
    logic                      r_respcyc;
    logic [BUS_TAG_WIDTH-1:0]  r_resptag;
    logic [c_BEAT_W-1:0]       w_first;

`ifdef SYSBUS_CRITWORD_EN
    logic [c_BEAT_W-1:0]       r_req_word;
    assign w_first = r_req_word;
`else
    assign w_first = '0;
`endif

    logic w_is_read;
    logic w_is_write;
    logic w_enter_resp;
    logic w_beat_ack;
    logic w_last;
    logic [c_BEAT_W-1:0]     w_rd_beat;
    logic [c_ADDR_WIDTH-1:0] w_rd_addr;

    assign w_is_read  = (r_tag[c_TAG_TYPE_BIT] == c_SYSBUS_MEMORY) &&
                        (r_tag[c_TAG_CMD_HI:c_TAG_CMD_LO] == c_SYSBUS_READ);
    assign w_is_write = (r_tag[c_TAG_TYPE_BIT] == c_SYSBUS_MEMORY) &&
                        (r_tag[c_TAG_CMD_HI:c_TAG_CMD_LO] == c_SYSBUS_WRITE);

    // The first beat is fetched on the edge that enters RESP so that its data
    // is valid in the same cycle respcyc rises.
    assign w_enter_resp = ((r_state == ACCEPT) && w_is_read && (LATENCY == 1)) ||
                          ((r_state == DELAY) && (r_delay == c_DLY_W'(1)));
    assign w_beat_ack   = (r_state == RESP) && bus_respack;
    assign w_last       = (r_beat == c_LAST_BEAT);
    assign w_rd_beat    = w_enter_resp ? '0 : r_beat + 1'b1;
    assign w_rd_addr    = {r_line, w_first + w_rd_beat};

    sysbus_mem_array #(
        .MEM_WORDS  (MEM_WORDS),
        .DATA_WIDTH (BUS_DATA_WIDTH),
        .ADDR_WIDTH (c_ADDR_WIDTH)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (reset && (r_state == WDATA) && bus_reqcyc),
        .i_wr_addr ({r_line, r_beat}),
        .i_wr_data (bus_req),
        .i_rd_en   (w_enter_resp || (w_beat_ack && !w_last)),
        .i_rd_clr  (!reset || (w_beat_ack && w_last)),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (bus_resp)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_reqack  <= 1'b0;
            r_respcyc <= 1'b0;
            r_resptag <= '0;
            r_beat    <= '0;
            r_delay   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus_reqcyc) begin
                        r_line   <= bus_req[c_LINE_SHIFT +: c_LINE_IDX_W];
                        r_tag    <= bus_reqtag;
`ifdef SYSBUS_CRITWORD_EN
                        r_req_word <= bus_req[c_LINE_SHIFT-1 -: c_BEAT_W];
`endif
                        r_reqack <= 1'b1;
                        r_state  <= ACCEPT;
                    end
                end
                ACCEPT: begin
                    r_beat <= '0;
                    if (w_is_read) begin
                        r_reqack <= 1'b0;
                        if (LATENCY == 1) begin
                            r_respcyc <= 1'b1;
                            r_resptag <= r_tag;
                            r_state   <= RESP;
                        end else begin
                            r_delay <= c_DLY_W'(LATENCY - 1);
                            r_state <= DELAY;
                        end
                    end else if (w_is_write) begin
                        r_state <= WDATA;
                    end else begin
                        r_reqack <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                WDATA: begin
                    if (bus_reqcyc) begin
                        r_beat <= r_beat + 1'b1;
                        if (w_last) begin
                            r_reqack <= 1'b0;
                            r_state  <= IDLE;
                        end
                    end
                end
                DELAY: begin
                    if (w_enter_resp) begin
                        r_respcyc <= 1'b1;
                        r_resptag <= r_tag;
                        r_beat    <= '0;
                        r_state   <= RESP;
                    end else begin
                        r_delay <= r_delay - 1'b1;
                    end
                end
                RESP: begin
                    if (bus_respack) begin
                        r_beat <= r_beat + 1'b1;
                        if (w_last) begin
                            r_respcyc <= 1'b0;
                            r_resptag <= '0;
                            r_state   <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus_reqack  = r_reqack;
    assign bus_respcyc = r_respcyc;
    assign bus_resptag = r_resptag;

endmodule

`default_nettype wire
